pong_frame_engine: RTL
======================

# pong_frame_engine

Parametrised game-state and pixel engine for the Pong display path, successor to the first fixed-resolution image generator. It holds paddle, ball and score state, advances it once per video frame from player button inputs, and produces a registered 3-bit colour for every (x, y) the VGA timing block scans. It sits between the VGA sync/counter block, which supplies `x`, `y` and `frame_start`, and the DAC pins.

## Interface
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in lines.
- `PADDLE_W`, 8 / `PADDLE_H`, 64: paddle size in pixels.
- `PADDLE_X_1`, 16 / `PADDLE_X_2`, 616: left edge x of the player 1 and player 2 paddles.
- `BALL_SIZE`, 8: ball edge length; the ball is square.
- `PADDLE_SPEED`, 4 / `BALL_SPEED`, 2: pixels moved per frame.
- `SERVE_FRAMES`, 60: frames of pause before each serve.
- `WIN_SCORE`, 9: score that ends the game; must be ≤ 15.
- `COLOR_BG`, 3'b000 / `COLOR_P1`, 3'b010 / `COLOR_P2`, 3'b001 / `COLOR_BALL`, 3'b111: RGB colours.

Ports:
- `CLOCK_25` in 1: pixel clock. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `x` in 12: current scan column.
- `y` in 12: current scan line.
- `frame_start` in 1: single-cycle pulse during vertical blanking. It triggers one state update.
- `p1_up`, `p1_down`, `p2_up`, `p2_down` in 1 each: paddle buttons, already synchronised.
- `start` in 1: starts a new game from OVER.
- `color` out 3: pixel colour.
- `score_1`, `score_2` out 4: current scores.
- `game_over` out 1: high while the FSM is in OVER.

## Operation
- **FSM states:** SERVE, PLAY, OVER. All state advances only on cycles where `frame_start`=1.
- **SERVE:**
  - Decrement `serve_cnt` each frame.
  - When `serve_cnt`=0, go to PLAY; the ball does not move in that frame.
- **PLAY:**
  - Move the ball by ±`BALL_SPEED` on each axis according to the direction bits `dx` and `dy`, where 1 means right or down.
  - Apply the bounce and score rules below.
- **Wall bounce:**
  - Moving up with `by` < `BALL_SPEED`: set `by`=0 and flip `dy`.
  - Moving down with `by`+`BALL_SIZE`+`BALL_SPEED` > `V_ACTIVE`: set `by`=`V_ACTIVE`-`BALL_SIZE` and flip `dy`.
- **Paddle 1 hit:** all of the following must hold:
  - the ball is moving left;
  - the next `bx` ≤ `PADDLE_X_1`+`PADDLE_W`;
  - the current `bx` ≥ `PADDLE_X_1`+`PADDLE_W`;
  - the ball overlaps the paddle vertically: `by`+`BALL_SIZE` > `p1_y` and `by` < `p1_y`+`PADDLE_H`.

  On a hit, set `bx`=`PADDLE_X_1`+`PADDLE_W` and flip `dx`. Paddle 2 mirrors this using `PADDLE_X_2`-`BALL_SIZE`.
- **Simultaneous wall and paddle hit:** both corrections apply in the same frame.
- **Miss:**
  - Moving left with `bx` < `BALL_SPEED`: `score_2`++.
  - Moving right with `bx`+`BALL_SIZE`+`BALL_SPEED` > `H_ACTIVE`: `score_1`++.
  - On a miss, re-centre the ball: `bx`=(`H_ACTIVE`-`BALL_SIZE`)/2 and `by`=(`V_ACTIVE`-`BALL_SIZE`)/2.
  - Set `dx` toward the player who conceded. `dy` is unchanged.
  - If the new score equals `WIN_SCORE`, go to OVER. Otherwise load `serve_cnt`=`SERVE_FRAMES` and go to SERVE.
- **OVER:**
  - Ball, paddles and scores are frozen.
  - `start`=1 on a `frame_start` cycle clears both scores, re-centres ball and paddles, loads `serve_cnt`, and goes to SERVE.
  - `start` is ignored in other states.
- **Paddles (SERVE and PLAY):**
  - Up only: subtract `PADDLE_SPEED`, clamped at 0.
  - Down only: add `PADDLE_SPEED`, clamped at `V_ACTIVE`-`PADDLE_H`.
  - Both buttons or neither: hold position.
- **Arithmetic:** positions are 12-bit unsigned. All compares are done on 13-bit sums so they cannot wrap.
- **Pixel colour:**
  - Outside the active area (`x` ≥ `H_ACTIVE` or `y` ≥ `V_ACTIVE`): 3'b000.
  - Inside: priority is ball > paddle 1 > paddle 2 > background.
  - Membership ranges are half-open: ball when `x` ∈ [`bx`, `bx`+`BALL_SIZE`) and `y` ∈ [`by`, `by`+`BALL_SIZE`); paddles likewise.
- **Reset values:**
  - `color`=0, scores 0, `game_over`=0.
  - State SERVE, `serve_cnt`=`SERVE_FRAMES`.
  - Paddles at `y`=(`V_ACTIVE`-`PADDLE_H`)/2; ball centred; `dx`=1, `dy`=1.

## Timing
- `color` is registered: it reflects the `x`/`y` of the previous cycle, so latency is exactly 1 cycle.
- Game state updates on the `CLOCK_25` edge where `frame_start`=1. New positions appear in `color` from the next cycle.
- `score_1`, `score_2` and `game_over` are registered and change only on `frame_start` edges.
- `reset` has priority over `frame_start` and `start` in the same cycle. A reset mid-frame takes effect at the next edge, and `color` reads 0 in the following cycle.
- If `frame_start` is held high for N cycles, N updates occur; no edge detection is performed.

## Test plan
- **Reset, then scan pixels:**
  - (320,240) → `color`=3'b111 one cycle later.
  - (20,240) → 3'b010.
  - (620,240) → 3'b001.
  - (700,10) → 3'b000.
  - `score_1`=`score_2`=0.
- **Serve delay:** 60 `frame_start` pulses with no buttons → ball still at (316,236). The 62nd pulse → ball at (318,238).
- **Paddle clamp:** hold `p1_up` for 100 frames → `p1_y`=0. Hold `p1_up`+`p1_down` together → `p1_y` unchanged.
- **Paddle 1 miss:** `p1_y`=0 with the ball travelling left at `y`≈400 → `score_2`=1, ball at (316,236), `dx`=0 (served toward player 1), FSM in SERVE.
- **Win and restart:**
  - Drive 9 misses past paddle 2 → `score_1`=9, `game_over`=1, ball frozen across 10 frames.
  - `start`+`frame_start` → scores 0, `game_over`=0.
- **Corner hit:** ball moving up-left at `by`=1 while a paddle-1 hit condition holds → in the same frame `by`=0, `bx`=24, and both `dx` and `dy` flip.

Source files
------------

// File: rtl/pong_frame_engine.sv
`timescale 1ns/1ps
// Pong game-state engine: paddles, ball and scores advance once per frame_start,
// and a registered 3-bit colour is produced for every scanned (x, y).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_SERVE | ball parked at centre, serve_cnt counting down
// ST_PLAY  | ball moving, bounce/score rules active
// ST_OVER  | a player reached WIN_SCORE, waiting for start
module pong_frame_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X_1   = 16,
    parameter int PADDLE_X_2   = 616,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9,
    parameter logic [2:0] COLOR_BG   = 3'b000,
    parameter logic [2:0] COLOR_P1   = 3'b010,
    parameter logic [2:0] COLOR_P2   = 3'b001,
    parameter logic [2:0] COLOR_BALL = 3'b111
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic        frame_start,
    input  logic        p1_up,
    input  logic        p1_down,
    input  logic        p2_up,
    input  logic        p2_down,
    input  logic        start,
    output logic [2:0]  color,
    output logic [3:0]  score_1,
    output logic [3:0]  score_2,
    output logic        game_over
);
    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    localparam int CW = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES);

    localparam logic [11:0] BX_C   = 12'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [11:0] BY_C   = 12'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [11:0] PY_C   = 12'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [11:0] BY_MAX = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic [11:0] X1_HIT = 12'(PADDLE_X_1 + PADDLE_W);
    localparam logic [11:0] X2_HIT = 12'(PADDLE_X_2 - BALL_SIZE);
    localparam logic [12:0] PY_MAX = 13'(V_ACTIVE - PADDLE_H);

    localparam logic [12:0] HA  = 13'(H_ACTIVE);
    localparam logic [12:0] VA  = 13'(V_ACTIVE);
    localparam logic [12:0] BS  = 13'(BALL_SIZE);
    localparam logic [12:0] SP  = 13'(BALL_SPEED);
    localparam logic [12:0] PSP = 13'(PADDLE_SPEED);
    localparam logic [12:0] PW  = 13'(PADDLE_W);
    localparam logic [12:0] PH  = 13'(PADDLE_H);
    localparam logic [12:0] X1  = 13'(PADDLE_X_1);
    localparam logic [12:0] X2  = 13'(PADDLE_X_2);
    localparam logic [3:0]  WIN = 4'(WIN_SCORE);

    logic [1:0]    state;
    logic [CW-1:0] serve_cnt;
    logic [11:0]   bx, by, p1_y, p2_y;
    logic          dx, dy;

    logic [12:0] bx13, by13, nbx, nby, x13, y13;
    logic [11:0] bx_n, by_n;
    logic        dx_n, dy_n, v1, v2, miss_l, miss_r;
    logic [3:0]  s1_inc, s2_inc;
    logic [2:0]  pixel;

    function automatic logic [11:0] paddle_next(input logic [11:0] py,
                                                input logic up, input logic down);
        logic [12:0] p;
        p = {1'b0, py};
        if (up && !down)
            return (p < PSP) ? 12'd0 : 12'(p - PSP);
        if (down && !up)
            return (p + PSP > PY_MAX) ? PY_MAX[11:0] : 12'(p + PSP);
        return py;
    endfunction

    // Ball motion candidates; compares stay in 13 bits so sums never wrap.
    always_comb begin
        bx13   = {1'b0, bx};
        by13   = {1'b0, by};
        nbx    = dx ? bx13 + SP : bx13 - SP;
        nby    = dy ? by13 + SP : by13 - SP;
        by_n   = nby[11:0];
        dy_n   = dy;
        bx_n   = nbx[11:0];
        dx_n   = dx;
        s1_inc = score_1 + 4'd1;
        s2_inc = score_2 + 4'd1;
        if (!dy && by13 < SP) begin
            by_n = 12'd0;
            dy_n = 1'b1;
        end else if (dy && by13 + BS + SP > VA) begin
            by_n = BY_MAX;
            dy_n = 1'b0;
        end
        v1 = (by13 + BS > {1'b0, p1_y}) && (by13 < {1'b0, p1_y} + PH);
        v2 = (by13 + BS > {1'b0, p2_y}) && (by13 < {1'b0, p2_y} + PH);
        if (!dx && nbx <= {1'b0, X1_HIT} && bx13 >= {1'b0, X1_HIT} && v1) begin
            bx_n = X1_HIT;
            dx_n = 1'b1;
        end else if (dx && nbx >= {1'b0, X2_HIT} && bx13 <= {1'b0, X2_HIT} && v2) begin
            bx_n = X2_HIT;
            dx_n = 1'b0;
        end
        miss_l = !dx && bx13 < SP;
        miss_r = dx && bx13 + BS + SP > HA;
    end

    always_comb begin
        x13   = {1'b0, x};
        y13   = {1'b0, y};
        pixel = 3'b000;
        if (x13 < HA && y13 < VA) begin
            if (x13 >= bx13 && x13 < bx13 + BS && y13 >= by13 && y13 < by13 + BS)
                pixel = COLOR_BALL;
            else if (x13 >= X1 && x13 < X1 + PW &&
                     y13 >= {1'b0, p1_y} && y13 < {1'b0, p1_y} + PH)
                pixel = COLOR_P1;
            else if (x13 >= X2 && x13 < X2 + PW &&
                     y13 >= {1'b0, p2_y} && y13 < {1'b0, p2_y} + PH)
                pixel = COLOR_P2;
            else
                pixel = COLOR_BG;
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state     <= ST_SERVE;
            serve_cnt <= SERVE_LOAD;
            bx        <= BX_C;
            by        <= BY_C;
            dx        <= 1'b1;
            dy        <= 1'b1;
            p1_y      <= PY_C;
            p2_y      <= PY_C;
            score_1   <= 4'd0;
            score_2   <= 4'd0;
            color     <= 3'b000;
        end else begin
            color <= pixel;
            if (frame_start) begin
                case (state)
                    ST_SERVE: begin
                        p1_y <= paddle_next(p1_y, p1_up, p1_down);
                        p2_y <= paddle_next(p2_y, p2_up, p2_down);
                        if (serve_cnt == '0)
                            state <= ST_PLAY;
                        else
                            serve_cnt <= serve_cnt - 1'b1;
                    end
                    ST_PLAY: begin
                        p1_y <= paddle_next(p1_y, p1_up, p1_down);
                        p2_y <= paddle_next(p2_y, p2_up, p2_down);
                        if (miss_l || miss_r) begin
                            // Re-serve toward the player who conceded; dy is kept.
                            bx <= BX_C;
                            by <= BY_C;
                            dx <= miss_r;
                            if (miss_l) score_2 <= s2_inc;
                            else        score_1 <= s1_inc;
                            if ((miss_l && s2_inc == WIN) || (miss_r && s1_inc == WIN)) begin
                                state <= ST_OVER;
                            end else begin
                                serve_cnt <= SERVE_LOAD;
                                state     <= ST_SERVE;
                            end
                        end else begin
                            bx <= bx_n;
                            by <= by_n;
                            dx <= dx_n;
                            dy <= dy_n;
                        end
                    end
                    ST_OVER: begin
                        if (start) begin
                            score_1   <= 4'd0;
                            score_2   <= 4'd0;
                            bx        <= BX_C;
                            by        <= BY_C;
                            p1_y      <= PY_C;
                            p2_y      <= PY_C;
                            serve_cnt <= SERVE_LOAD;
                            state     <= ST_SERVE;
                        end
                    end
                    default: state <= ST_SERVE;
                endcase
            end
        end
    end

    assign game_over = (state == ST_OVER);
endmodule
